// File: rtl/cajero_pkg.sv
// Shared constants for the cashier session controller: FSM encoding, BCD digit codes,
// transaction types and datapath widths.
package cajero_pkg;

  localparam int PIN_W = 16;
  localparam int BAL_W = 32;

  localparam logic [5:0] ST_IDLE    = 6'b00_0001;
  localparam logic [5:0] ST_PIN     = 6'b00_0010;
  localparam logic [5:0] ST_CHECK   = 6'b00_0100;
  localparam logic [5:0] ST_MONTO   = 6'b00_1000;
  localparam logic [5:0] ST_EXEC    = 6'b01_0000;
  localparam logic [5:0] ST_BLOQUEO = 6'b10_0000;

  typedef enum logic [5:0] {
    EST_IDLE    = ST_IDLE,
    EST_PIN     = ST_PIN,
    EST_CHECK   = ST_CHECK,
    EST_MONTO   = ST_MONTO,
    EST_EXEC    = ST_EXEC,
    EST_BLOQUEO = ST_BLOQUEO
  } estado_t;

  localparam logic [3:0] DIG_CERO   = 4'd0;
  localparam logic [3:0] DIG_UNO    = 4'd1;
  localparam logic [3:0] DIG_DOS    = 4'd2;
  localparam logic [3:0] DIG_TRES   = 4'd3;
  localparam logic [3:0] DIG_CUATRO = 4'd4;
  localparam logic [3:0] DIG_CINCO  = 4'd5;
  localparam logic [3:0] DIG_SEIS   = 4'd6;
  localparam logic [3:0] DIG_SIETE  = 4'd7;
  localparam logic [3:0] DIG_OCHO   = 4'd8;
  localparam logic [3:0] DIG_NUEVE  = 4'd9;
  localparam logic [3:0] DIG_VACIO  = 4'hF;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  function automatic logic es_bcd(input logic [3:0] d);
    return d <= DIG_NUEVE;
  endfunction

endpackage

// File: rtl/cajero_captura_pin.sv
// PIN capture: filters non-BCD keys, shifts accepted digits in MSB-first and counts them.
// completo is combinational and marks the strobe that delivers the last digit.
module cajero_captura_pin
  import cajero_pkg::*;
#(
  parameter int N_DIGITOS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   digito_stb,
  input  logic [3:0]             digito,
  output logic [4*N_DIGITOS-1:0] pin_rx,
  output logic                   completo
);

  localparam int PW = 4 * N_DIGITOS;
  localparam int CW = $clog2(N_DIGITOS + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(N_DIGITOS - 1);

  logic [PW-1:0] pin_rx_q, pin_rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acepta;

  always_comb begin
    acepta   = digito_stb && es_bcd(digito);
    completo = acepta && (cnt_q == ULTIMO);
    pin_rx_d = pin_rx_q;
    cnt_d    = cnt_q;
    if (clear) begin
      pin_rx_d = '0;
      cnt_d    = '0;
    end else if (acepta) begin
      pin_rx_d = {pin_rx_q[PW-5:0], digito};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pin_rx_q <= '0;
      cnt_q    <= '0;
    end else begin
      pin_rx_q <= pin_rx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pin_rx = pin_rx_q;

endmodule

// File: rtl/cajero_control_transaccion.sv
// Card session controller: PIN entry/check with attempt lockout, then one deposit or
// withdrawal; results appear one cycle after monto_stb, all outputs registered.
module cajero_control_transaccion
  import cajero_pkg::*;
#(
  parameter int MAX_INTENTOS = 3,
  parameter int N_DIGITOS    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tarjeta_recibida,
  input  logic                   tipo_trans,
  input  logic                   digito_stb,
  input  logic [3:0]             digito,
  input  logic [4*N_DIGITOS-1:0] pin,
  input  logic [BAL_W-1:0]       balance_inicial,
  input  logic                   monto_stb,
  input  logic [BAL_W-1:0]       monto,
  output logic [BAL_W-1:0]       balance_actualizado,
  output logic                   balance_stb,
  output logic                   entregar_dinero,
  output logic                   pin_incorrecto,
  output logic                   advertencia,
  output logic                   bloqueo,
  output logic                   fondos_insuficientes
);

  localparam int PW = 4 * N_DIGITOS;
  localparam int IW = $clog2(MAX_INTENTOS + 1);
  localparam logic [IW-1:0] INT_AVISO = IW'(MAX_INTENTOS - 1);
  localparam logic [IW-1:0] INT_BLOQ  = IW'(MAX_INTENTOS);

  estado_t          state_q, state_d;
  logic [IW-1:0]    intentos_q, intentos_d, intentos_inc;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] monto_q, monto_d;
  logic             tipo_q, tipo_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;
  logic             bal_stb_q, bal_stb_d;
  logic             entregar_q, entregar_d;
  logic             pin_inc_q, pin_inc_d;
  logic             adv_q, adv_d;
  logic             bloq_q, bloq_d;
  logic             fondos_q, fondos_d;

  logic             dig_en, pin_clr, pin_completo;
  logic [PW-1:0]    pin_rx;
  logic [BAL_W:0]   suma;
  logic [BAL_W-1:0] resultado;

  // Abort (card removed) takes precedence over a digit arriving on the same edge.
  assign dig_en  = digito_stb && tarjeta_recibida && (state_q == EST_PIN);
  assign pin_clr = (state_q == EST_IDLE) || (state_q == EST_CHECK);

  cajero_captura_pin #(
    .N_DIGITOS (N_DIGITOS)
  ) u_captura (
    .clock      (clock),
    .reset      (reset),
    .clear      (pin_clr),
    .digito_stb (dig_en),
    .digito     (digito),
    .pin_rx     (pin_rx),
    .completo   (pin_completo)
  );

  assign suma = {1'b0, balance_q} + {1'b0, monto_q};

  always_comb begin
    state_d      = state_q;
    intentos_d   = intentos_q;
    intentos_inc = intentos_q + 1'b1;
    balance_d    = balance_q;
    monto_d      = monto_q;
    tipo_d       = tipo_q;
    bal_out_d    = bal_out_q;
    bal_stb_d    = 1'b0;
    entregar_d   = 1'b0;
    pin_inc_d    = 1'b0;
    fondos_d     = 1'b0;
    adv_d        = adv_q;
    bloq_d       = bloq_q;
    resultado    = balance_q;

    unique case (state_q)
      EST_IDLE: begin
        if (tarjeta_recibida) begin
          state_d   = EST_PIN;
          balance_d = balance_inicial;
        end
      end
      EST_PIN: begin
        if (!tarjeta_recibida)  state_d = EST_IDLE;
        else if (pin_completo)  state_d = EST_CHECK;
      end
      EST_CHECK: begin
        if (!tarjeta_recibida) begin
          state_d = EST_IDLE;
        end else if (pin_rx == pin) begin
          intentos_d = '0;
          adv_d      = 1'b0;
          state_d    = EST_MONTO;
        end else begin
          intentos_d = intentos_inc;
          pin_inc_d  = 1'b1;
          if (intentos_inc == INT_BLOQ) begin
            bloq_d  = 1'b1;
            state_d = EST_BLOQUEO;
          end else begin
            if (intentos_inc == INT_AVISO) adv_d = 1'b1;
            state_d = EST_PIN;
          end
        end
      end
      EST_MONTO: begin
        if (!tarjeta_recibida) begin
          state_d = EST_IDLE;
        end else if (monto_stb) begin
          monto_d = monto;
          tipo_d  = tipo_trans;
          state_d = EST_EXEC;
        end
      end
      EST_EXEC: begin
        if (tipo_q == TIPO_RETIRO) begin
          if (monto_q <= balance_q) begin
            resultado  = balance_q - monto_q;
            entregar_d = 1'b1;
          end else begin
            fondos_d   = 1'b1;
          end
        end else begin
          // Deposits saturate rather than wrap on carry-out.
          resultado = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
        end
        balance_d = resultado;
        bal_out_d = resultado;
        bal_stb_d = 1'b1;
        state_d   = EST_IDLE;
      end
      EST_BLOQUEO: state_d = EST_BLOQUEO;
      default:     state_d = EST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= EST_IDLE;
      intentos_q <= '0;
      balance_q  <= '0;
      monto_q    <= '0;
      tipo_q     <= TIPO_DEPOSITO;
      bal_out_q  <= '0;
      bal_stb_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      intentos_q <= intentos_d;
      balance_q  <= balance_d;
      monto_q    <= monto_d;
      tipo_q     <= tipo_d;
      bal_out_q  <= bal_out_d;
      bal_stb_q  <= bal_stb_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      fondos_q   <= fondos_d;
    end
  end

  assign balance_actualizado  = bal_out_q;
  assign balance_stb          = bal_stb_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloq_q;
  assign fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_cajero_control_transaccion.sv
// Bench for the cashier session controller: directed sessions feed an expected-event
// queue; a monitor compares every observed output event against it.
module tb_cajero_control_transaccion;
  import cajero_pkg::*;

  typedef struct packed {
    logic        stb;
    logic [31:0] bal;
    logic        ent;
    logic        inc;
    logic        adv;
    logic        bloq;
    logic        fon;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic [15:0] pin;
  logic [31:0] balance_inicial;
  logic        monto_stb;
  logic [31:0] monto;
  logic [31:0] balance_actualizado;
  logic        balance_stb, entregar_dinero, pin_incorrecto;
  logic        advertencia, bloqueo, fondos_insuficientes;

  int    checks   = 0;
  int    failures = 0;
  ev_t   exp_q[$];
  string nom_q[$];
  ev_t   cur, e;
  string nm;
  logic  adv_prev  = 1'b0;
  logic  bloq_prev = 1'b0;

  always #5 clock = ~clock;

  cajero_control_transaccion #(
    .MAX_INTENTOS (3),
    .N_DIGITOS    (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito_stb           (digito_stb),
    .digito               (digito),
    .pin                  (pin),
    .balance_inicial      (balance_inicial),
    .monto_stb            (monto_stb),
    .monto                (monto),
    .balance_actualizado  (balance_actualizado),
    .balance_stb          (balance_stb),
    .entregar_dinero      (entregar_dinero),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .fondos_insuficientes (fondos_insuficientes)
  );

  function automatic ev_t mk(input logic s, input logic [31:0] b, input logic en,
                             input logic in, input logic a, input logic bl, input logic f);
    ev_t r;
    r.stb = s; r.bal = b; r.ent = en; r.inc = in; r.adv = a; r.bloq = bl; r.fon = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input string n, input ev_t v);
    exp_q.push_back(v);
    nom_q.push_back(n);
  endtask

  task automatic dig(input logic [3:0] d);
    digito = d; digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
  endtask

  // Four digits then the CHECK cycle.
  task automatic pin4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    dig(a); dig(b); dig(c); dig(d);
    tick();
  endtask

  task automatic insert_card(input logic [31:0] bal);
    balance_inicial  = bal;
    tarjeta_recibida = 1'b1;
    tick();
  endtask

  // Strobe the amount, pull the card during EXEC so no new session starts.
  task automatic do_monto(input logic [31:0] m, input logic t);
    monto = m; tipo_trans = t; monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0; tarjeta_recibida = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; tarjeta_recibida = 1'b0; tipo_trans = 1'b0; digito_stb = 1'b0;
    digito = 4'd0; pin = 16'h1234; balance_inicial = 32'd0; monto_stb = 1'b0; monto = 32'd0;
    tick(); tick();
    reset = 1'b1;

    checks++;
    if ({balance_actualizado, balance_stb, entregar_dinero, pin_incorrecto, advertencia,
         bloqueo, fondos_insuficientes} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {balance_actualizado, balance_stb,
               entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes});
    end

    fork
      forever begin
        @(negedge clock);
        cur = mk(balance_stb, balance_actualizado, entregar_dinero, pin_incorrecto,
                 advertencia, bloqueo, fondos_insuficientes);
        if (cur.stb || cur.ent || cur.inc || cur.fon || (cur.adv != adv_prev) || (cur.bloq != bloq_prev)) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got=%h required=none", cur);
          end else begin
            e  = exp_q.pop_front();
            nm = nom_q.pop_front();
            if (cur !== e) begin
              failures++;
              $display("FAIL %s got=%h required=%h", nm, cur, e);
            end
          end
        end
        adv_prev  = cur.adv;
        bloq_prev = cur.bloq;
      end
    join_none

    // Correct PIN, deposit 100 + 50.
    expect_ev("deposit_150", mk(1, 32'd150, 0, 0, 0, 0, 0));
    insert_card(32'd100);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    do_monto(32'd50, TIPO_DEPOSITO);

    // Withdraw the whole balance, then an overdraw against zero.
    expect_ev("withdraw_exact", mk(1, 32'd0, 1, 0, 0, 0, 0));
    insert_card(32'd100);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    do_monto(32'd100, TIPO_RETIRO);
    expect_ev("withdraw_reject", mk(1, 32'd0, 0, 0, 0, 0, 1));
    insert_card(32'd0);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    do_monto(32'd1, TIPO_RETIRO);

    // Three wrong PINs on one card lead to lockout.
    insert_card(32'd100);
    expect_ev("wrong_1", mk(0, 32'd0, 0, 1, 0, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    expect_ev("wrong_2_warn", mk(0, 32'd0, 0, 1, 1, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    expect_ev("wrong_3_lock", mk(0, 32'd0, 0, 1, 1, 1, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    checks++;
    if (dut.state_q !== EST_BLOQUEO) begin
      failures++;
      $display("FAIL state_bloqueo got=%h required=%h", dut.state_q, EST_BLOQUEO);
    end
    monto = 32'd10; tipo_trans = TIPO_DEPOSITO; monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0; tarjeta_recibida = 1'b0;
    tick();
    tarjeta_recibida = 1'b1;
    tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) tick();
    tarjeta_recibida = 1'b0;
    expect_ev("reset_clears_lock", mk(0, 32'd0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Two wrong PINs, card cycled, correct PIN clears the warning and the count.
    insert_card(32'd100);
    expect_ev("rec_wrong_1", mk(0, 32'd0, 0, 1, 0, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    expect_ev("rec_wrong_2", mk(0, 32'd0, 0, 1, 1, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    tarjeta_recibida = 1'b0;
    tick();
    insert_card(32'd100);
    expect_ev("rec_adv_clear", mk(0, 32'd0, 0, 0, 0, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++;
    if (dut.intentos_q !== 2'd0) begin
      failures++;
      $display("FAIL attempts_cleared got=%0d required=0", dut.intentos_q);
    end
    tarjeta_recibida = 1'b0;
    tick();
    insert_card(32'd100);
    expect_ev("rec_wrong_again", mk(0, 32'd0, 0, 1, 0, 0, 0));
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    tarjeta_recibida = 1'b0;
    tick();

    // Non-BCD key mid-entry is ignored.
    expect_ev("filter_deposit", mk(1, 32'd205, 0, 0, 0, 0, 0));
    insert_card(32'd200);
    dig(4'd1); dig(4'd2); dig(DIG_VACIO); dig(4'd3); dig(4'd4);
    tick();
    do_monto(32'd5, TIPO_DEPOSITO);

    // Card removed on the same cycle as monto_stb: no transaction.
    insert_card(32'd200);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    monto = 32'd7; tipo_trans = TIPO_DEPOSITO; monto_stb = 1'b1; tarjeta_recibida = 1'b0;
    tick();
    monto_stb = 1'b0;
    tick();
    checks++;
    if (dut.state_q !== EST_IDLE) begin
      failures++;
      $display("FAIL abort_idle got=%h required=%h", dut.state_q, EST_IDLE);
    end

    // Saturating deposit.
    expect_ev("deposit_saturate", mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
    insert_card(32'hFFFF_FFF0);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    do_monto(32'h20, TIPO_DEPOSITO);

    // Reset during PIN entry.
    insert_card(32'd5);
    dig(4'd1); dig(4'd2);
    reset = 1'b0;
    tick();
    checks++;
    if ({balance_actualizado, balance_stb, entregar_dinero, pin_incorrecto, advertencia,
         bloqueo, fondos_insuficientes} !== 38'd0) begin
      failures++;
      $display("FAIL reset_in_pin got=%h required=0", {balance_actualizado, balance_stb,
               entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes});
    end
    checks++;
    if (dut.state_q !== EST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h", dut.state_q, EST_IDLE);
    end
    tarjeta_recibida = 1'b0;
    reset = 1'b1;
    repeat (5) tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
